// File: rtl/wptr_full_level.sv
// wptr_full_level: write-side pointer and status block for the async FIFO.
// Keeps the binary and Gray write pointers. Compares them against the read
// pointer, which has already been synchronised into wclk. Drives the RAM write
// address, the full and almost-full flags, a registered fill level and an
// optional sticky overflow flag.
// Optional feature macro: WPTR_OVF_EN. It builds the sticky overflow register
// behind wovf. When the macro is undefined, wovf is tied low.
module wptr_full_level #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = (1 << ADDRSIZE) - 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE + 1)'(AFULL_THRESH);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] lvl_next;
  logic [ADDRSIZE:0] full_gray;
  logic              wpush;
  logic              wfull_next;
  logic              wafull_next;

  assign waddr = wbin[ADDRSIZE-1:0];

  // A write is accepted only while the FIFO is not full. Dropped writes leave the pointer alone.
  always_comb begin
    wpush     = winc & ~wfull;
    wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wpush};
    wgraynext = (wbinnext >> 1) ^ wbinnext;
  end

  // Convert the synchronised Gray read pointer back to binary so it can be subtracted.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  // Next level comes from modular subtraction, so it stays correct across pointer wrap.
  // Full is the classic Gray compare: the top two bits are inverted and the rest are equal.
  always_comb begin
    lvl_next    = wbinnext - rbin;
    full_gray   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    wfull_next  = (wgraynext == full_gray);
    wafull_next = (lvl_next >= AFULL_LVL);
  end

  // Pointer, flag and level registers all update together on every write-clock edge.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      wafull <= 1'b0;
      wlevel <= '0;
    end else begin
      wbin   <= wbinnext;
      wptr   <= wgraynext;
      wfull  <= wfull_next;
      wafull <= wafull_next;
      wlevel <= lvl_next;
    end
  end

`ifdef WPTR_OVF_EN
  // Sticky overflow: it records any write attempted while full, and only reset clears it.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf <= 1'b0;
    end else begin
      wovf <= wovf | (winc & wfull);
    end
  end
`else
  assign wovf = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_level.sv
// tb_wptr_full_level: directed checks of the write pointer, full, almost-full,
// level and overflow behaviour for ADDRSIZE=4 with AFULL_THRESH=12.
module tb_wptr_full_level;

  localparam int ADDRSIZE = 4;
  localparam int DEPTH    = 16;

  logic                wclk;
  logic                wrst_n;
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                wafull;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;

  int checks = 0;
  int errors = 0;

`ifdef WPTR_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  wptr_full_level #(.ADDRSIZE(ADDRSIZE), .AFULL_THRESH(12)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .winc     (winc),
    .wq2_rptr (wq2_rptr),
    .waddr    (waddr),
    .wptr     (wptr),
    .wfull    (wfull),
    .wafull   (wafull),
    .wlevel   (wlevel),
    .wovf     (wovf)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [ADDRSIZE:0] gray(input int n);
    logic [ADDRSIZE:0] b;
    b = ADDRSIZE'(0) + (ADDRSIZE + 1)'(n);
    return (b >> 1) ^ b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic checkAll(input string tag, input int expAddr, input int expPtr, input logic expFull,
                          input logic expAfull, input int expLevel, input logic expOvf);
    checkOutput({tag, ".waddr"},  32'(waddr),  32'(expAddr));
    checkOutput({tag, ".wptr"},   32'(wptr),   32'(expPtr));
    checkOutput({tag, ".wfull"},  32'(wfull),  32'(expFull));
    checkOutput({tag, ".wafull"}, 32'(wafull), 32'(expAfull));
    checkOutput({tag, ".wlevel"}, 32'(wlevel), 32'(expLevel));
    checkOutput({tag, ".wovf"},   32'(wovf),   32'(expOvf));
  endtask

  // One clock step: drive inputs, then wait until just after the next rising edge.
  task automatic applyStimulus(input logic inc, input logic [ADDRSIZE:0] rptr);
    winc     = inc;
    wq2_rptr = rptr;
    @(posedge wclk);
    #1;
  endtask

  initial begin
    logic [ADDRSIZE:0] prevPtr;
    int wraps;
    int r;

    winc     = 1'b0;
    wq2_rptr = '0;
    wrst_n   = 1'b0;
    #1;
    checkAll("reset_initial", 0, 0, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, '0);
    wrst_n = 1'b1;

    // Start a burst, then assert reset between clock edges.
    applyStimulus(1'b1, '0);
    applyStimulus(1'b1, '0);
    applyStimulus(1'b1, '0);
    checkAll("burst3", 3, 2, 1'b0, 1'b0, 3, 1'b0);
    #2;
    wrst_n = 1'b0;
    #1;
    checkAll("reset_mid_burst", 0, 0, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, '0);
    checkAll("reset_held_winc", 0, 0, 1'b0, 1'b0, 0, 1'b0);
    wrst_n = 1'b1;

    // Fill from empty to full with 16 consecutive writes.
    for (int k = 1; k <= DEPTH; k++) begin
      applyStimulus(1'b1, '0);
      checkAll($sformatf("fill%0d", k), k % DEPTH, int'(gray(k)), (k == DEPTH), (k >= 12), k, 1'b0);
      checkOutput($sformatf("fill%0d.full_eq_level", k), 32'(wfull), 32'(wlevel == 5'd16));
    end
    checkOutput("full_gray16", 32'(wptr), 32'b11000);

    // Three writes while full are dropped.
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, '0);
      checkAll($sformatf("ovf%0d", k), 0, 5'b11000, 1'b1, 1'b1, 16, OVF_ON);
    end

    // The read side frees one entry, then four more.
    applyStimulus(1'b0, 5'b00001);
    checkAll("drain1", 0, 5'b11000, 1'b0, 1'b1, 15, OVF_ON);
    applyStimulus(1'b0, 5'b00111);
    checkAll("drain5", 0, 5'b11000, 1'b0, 1'b0, 11, OVF_ON);

    // Bring the level back to 15, then write while the read side also advances.
    applyStimulus(1'b0, 5'b00001);
    checkAll("relevel15", 0, 5'b11000, 1'b0, 1'b1, 15, OVF_ON);
    applyStimulus(1'b1, 5'b00011);
    checkAll("simultaneous", 1, 5'b11001, 1'b0, 1'b1, 15, OVF_ON);

    // Reset clears everything, including the sticky overflow.
    wrst_n = 1'b0;
    #1;
    checkAll("reset_again", 0, 0, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, '0);
    wrst_n = 1'b1;

    // Forty writes with the read pointer trailing, so both pointers wrap.
    prevPtr = wptr;
    wraps   = 0;
    for (int n = 1; n <= 40; n++) begin
      r = (n > 3) ? n - 3 : 0;
      applyStimulus(1'b1, gray(r % (2 * DEPTH)));
      checkOutput($sformatf("wrap%0d.waddr", n),  32'(waddr),  32'(n % DEPTH));
      checkOutput($sformatf("wrap%0d.wptr", n),   32'(wptr),   32'(gray(n % (2 * DEPTH))));
      checkOutput($sformatf("wrap%0d.wlevel", n), 32'(wlevel), 32'(n - r));
      checkOutput($sformatf("wrap%0d.wfull", n),  32'(wfull),  32'(0));
      checkOutput($sformatf("wrap%0d.onebit", n), 32'($countones(wptr ^ prevPtr)), 32'(1));
      if (waddr == '0) wraps++;
      prevPtr = wptr;
    end
    checkOutput("wrap_count", 32'(wraps), 32'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
